// File: rtl/pixel_burst_packer_pkg.sv
// Shared types and elaboration-time helpers for the pixel burst packer.
package pixel_burst_packer_pkg;

  typedef enum logic [1:0] {
    StFill,
    StReq,
    StWrite
  } state_e;

  // Number of BurstLength-word bursts needed to store one frame.
  function automatic int unsigned bursts_per_frame(input int unsigned width,
                                                   input int unsigned height,
                                                   input int unsigned burst_len);
    return (width * height) / burst_len;
  endfunction

  // Index width for a range of n values, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_burst_packer_if.sv
// FIFO-side and SDRAM-side signals of the pixel burst packer.
// PIXEL_PACKER_FRAME_SYNC_EN adds the i_frame_sync input.
interface pixel_burst_packer_if #(
  parameter int unsigned PixelBitWidth   = 16,
  parameter int unsigned AddressWidth    = 24,
  parameter int unsigned BurstCountWidth = 16
);
  logic                       i_fifo_empty;
  logic [PixelBitWidth-1:0]   i_fifo_data;
  logic                       o_fifo_rd_en;
  logic                       o_enable;
  logic                       o_rw;
  logic [AddressWidth-1:0]    o_addr;
  logic [PixelBitWidth-1:0]   o_data;
  logic                       i_busy;
  logic                       i_valid_wr;
  logic                       o_frame_done;
  logic [BurstCountWidth-1:0] o_burst_count;
`ifdef PIXEL_PACKER_FRAME_SYNC_EN
  logic                       i_frame_sync;
`endif

  // Packer side.
  modport master (
    input  i_fifo_empty, i_fifo_data, i_busy, i_valid_wr,
`ifdef PIXEL_PACKER_FRAME_SYNC_EN
    input  i_frame_sync,
`endif
    output o_fifo_rd_en, o_enable, o_rw, o_addr, o_data, o_frame_done, o_burst_count
  );

  // FIFO / SDRAM controller side.
  modport slave (
    output i_fifo_empty, i_fifo_data, i_busy, i_valid_wr,
`ifdef PIXEL_PACKER_FRAME_SYNC_EN
    output i_frame_sync,
`endif
    input  o_fifo_rd_en, o_enable, o_rw, o_addr, o_data, o_frame_done, o_burst_count
  );
endinterface

// File: rtl/pixel_burst_packer_burst_buffer.sv
// One burst worth of pixel words, written by index and read combinationally.
module pixel_burst_packer_burst_buffer #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 16,
  parameter int unsigned IdxW  = 3
) (
  input  logic             CLK,
  input  logic             wr_en_i,
  input  logic [IdxW-1:0]  wr_idx_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [IdxW-1:0]  rd_idx_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];

  // Store a returned FIFO word at the current fill position.
  always_ff @(posedge CLK) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/pixel_burst_packer.sv
// Pops pixels from the CLK-side FIFO, packs them into BurstLength-word bursts and
// issues one SDRAM write per burst at a frame-linear address.
// PIXEL_PACKER_FRAME_SYNC_EN enables realignment to BaseAddress on i_frame_sync.
module pixel_burst_packer
  import pixel_burst_packer_pkg::*;
#(
  parameter int unsigned PixelBitWidth = 16,
  parameter int unsigned FrameWidth    = 640,
  parameter int unsigned FrameHeight   = 480,
  parameter int unsigned BurstLength   = 8,
  parameter int unsigned AddressWidth  = 24,
  parameter int unsigned BaseAddress   = 0
) (
  input logic                  CLK,
  input logic                  RST,
  pixel_burst_packer_if.master bus
);

  localparam int unsigned BurstsPerFrame = bursts_per_frame(FrameWidth, FrameHeight, BurstLength);
  localparam int unsigned IdxW   = width_of(BurstLength);
  localparam int unsigned CountW = width_of(BurstsPerFrame);

  localparam logic [IdxW:0]         FillFull  = (IdxW + 1)'(BurstLength);
  localparam logic [IdxW:0]         FillLast  = (IdxW + 1)'(BurstLength - 1);
  localparam logic [IdxW-1:0]       LastWord  = IdxW'(BurstLength - 1);
  localparam logic [CountW-1:0]     LastBurst = CountW'(BurstsPerFrame - 1);
  localparam logic [AddressWidth-1:0] BaseAddr  = AddressWidth'(BaseAddress);
  localparam logic [AddressWidth-1:0] BurstStep = AddressWidth'(BurstLength);

  if ((FrameWidth * FrameHeight) % BurstLength != 0) begin : g_bad_frame
    $error("FrameWidth*FrameHeight must be a multiple of BurstLength");
  end
  if (BurstLength < 2 || (BurstLength & (BurstLength - 1)) != 0) begin : g_bad_burst
    $error("BurstLength must be a power of two of at least 2");
  end

  state_e                  state_q, state_d;
  logic [IdxW:0]           fill_q, fill_d;
  logic [IdxW-1:0]         word_q, word_d;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic [CountW-1:0]       count_q, count_d;
  logic                    done_q, done_d;
  logic                    pending_q, pending_d;
  logic                    rd_en_q, rd_en;
  logic                    buf_wr;
  logic [PixelBitWidth-1:0] buf_rd;
  logic                    frame_sync;

`ifdef PIXEL_PACKER_FRAME_SYNC_EN
  assign frame_sync = bus.i_frame_sync;
`else
  assign frame_sync = 1'b0;
`endif

  pixel_burst_packer_burst_buffer #(
    .Depth (BurstLength),
    .Width (PixelBitWidth),
    .IdxW  (IdxW)
  ) u_buffer (
    .CLK       (CLK),
    .wr_en_i   (buf_wr),
    .wr_idx_i  (fill_q[IdxW-1:0]),
    .wr_data_i (bus.i_fifo_data),
    .rd_idx_i  (word_q),
    .rd_data_o (buf_rd)
  );

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StFill;
      fill_q    <= '0;
      word_q    <= '0;
      addr_q    <= BaseAddr;
      count_q   <= '0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      pending_q <= pending_d;
      rd_en_q   <= rd_en;
    end
  end

  // Next-state logic: fill the buffer, request the bus, stream the burst out.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    word_d    = word_q;
    addr_d    = addr_q;
    count_d   = count_q;
    done_d    = 1'b0;
    pending_d = pending_q;
    rd_en     = 1'b0;
    buf_wr    = 1'b0;
    unique case (state_q)
      StFill: begin
        word_d = '0;
        if (frame_sync) begin
          // Drop the partial burst; the read returning this cycle is discarded.
          fill_d    = '0;
          addr_d    = BaseAddr;
          count_d   = '0;
          pending_d = 1'b0;
        end else begin
          // rd_en_q counts the one read whose data has not landed yet.
          rd_en  = !RST && !bus.i_fifo_empty && ((fill_q + (IdxW + 1)'(rd_en_q)) < FillFull);
          buf_wr = rd_en_q;
          if (rd_en_q) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == FillLast) state_d = StReq;
          end
        end
      end
      StReq: begin
        word_d = '0;
        if (frame_sync) pending_d = 1'b1;
        if (!bus.i_busy) state_d = StWrite;
      end
      StWrite: begin
        if (frame_sync) pending_d = 1'b1;
        if (bus.i_valid_wr) begin
          if (word_q == LastWord) begin
            state_d   = StFill;
            fill_d    = '0;
            word_d    = '0;
            pending_d = 1'b0;
            addr_d    = addr_q + BurstStep;
            count_d   = count_q + 1'b1;
            if (count_q == LastBurst) begin
              addr_d  = BaseAddr;
              count_d = '0;
              done_d  = 1'b1;
            end
            if (pending_q || frame_sync) begin
              addr_d  = BaseAddr;
              count_d = '0;
            end
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  assign bus.o_fifo_rd_en  = rd_en;
  assign bus.o_enable      = (state_q == StReq);
  assign bus.o_rw          = 1'b0;
  assign bus.o_addr        = addr_q;
  assign bus.o_data        = (state_q == StFill) ? '0 : buf_rd;
  assign bus.o_frame_done  = done_q;
  assign bus.o_burst_count = count_q;

endmodule
